if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, is the PC loaded at reset.
REQ-002: Parameter NOP, default 32'h0000_0000, is the bubble instruction placed in IF_ID.
REQ-003: clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004: rst_n  in  1  is the reset: synchronous, active-low.
REQ-005: stall  in  1  is the hazard hold; the PC and IF_ID SHALL be frozen while it is high.
REQ-006: redirect  in  1  is a taken branch/jump.
REQ-007: redirect_pc  in  32  is the branch/jump target.
REQ-008: imem_req  out  1  is the instruction-memory fetch request.
REQ-009: imem_addr  out  32  is the fetch address, equal to the current PC.
REQ-010: imem_ready  in  1  means the memory returns imem_rdata this cycle.
REQ-011: imem_rdata  in  32  is the fetched instruction word.
REQ-012: IF_ID  out  32  is the instruction register feeding decode.
REQ-013: pc_plus4  out  32  is the PC+4 of the instruction held in IF_ID.
REQ-014: if_valid  out  1  is high when IF_ID holds a real (non-bubble) instruction.

Function
REQ-015: A fetch SHALL complete in any cycle where imem_req and imem_ready are both high; imem_addr may change freely in cycles without completion.
REQ-016: The FSM SHALL have two states: FETCH and HELD.
REQ-017: imem_req SHALL be high only when state is FETCH, rst_n is high, and redirect is low.
REQ-018: HELD SHALL own a 1-entry buffer holding {instruction, PC+4}.
REQ-019: Priority SHALL be reset > redirect > stall > normal.
REQ-020: On redirect, the block SHALL load PC with {redirect_pc[31:2],2'b00}, set IF_ID=NOP and if_valid=0, discard the buffer, and go to FETCH. This applies in both states and regardless of stall.
REQ-021: Stall in FETCH with completion: the block SHALL write the buffer with {imem_rdata, PC+4}, set PC=PC+4, go to HELD, and leave IF_ID, pc_plus4 and if_valid unchanged.
REQ-022: Stall in FETCH without completion, or stall in HELD: all state SHALL be held.
REQ-023: No stall, state HELD: the block SHALL set IF_ID/pc_plus4 from the buffer, set if_valid=1, go to FETCH, and leave PC unchanged.
REQ-024: No stall, state FETCH, completion: the block SHALL set IF_ID=imem_rdata, pc_plus4=PC+4, if_valid=1, and PC=PC+4.
REQ-025: No stall, state FETCH, no completion: the block SHALL set IF_ID=NOP and if_valid=0, and hold PC and pc_plus4.
REQ-026: PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000.
REQ-027: Fetch latency SHALL be one cycle: a word completing in cycle N SHALL appear in IF_ID after edge N+1 (no stall).
REQ-028: An instruction SHALL never be lost or duplicated across any stall/ready interleaving absent redirect.

Reset
REQ-029: While rst_n is low at a rising edge, the block SHALL set PC=RESET_PC, IF_ID=NOP, pc_plus4=RESET_PC, if_valid=0, state=FETCH, and clear the buffer.
REQ-030: While rst_n is low, imem_req SHALL be 0.
REQ-031: Reset asserted mid-operation (HELD, or during a pending fetch) SHALL discard all in-flight data with no further effect.
REQ-032: The first request SHALL issue in the first cycle with rst_n high, at imem_addr=RESET_PC.

Verification
REQ-033: Reset release, imem_ready=1 every cycle, words 0x11,0x22,0x33 -> IF_ID sequence 0x11,0x22,0x33 on consecutive cycles; pc_plus4 = 4, 8, 12; if_valid=1.
REQ-034: imem_ready low 2 cycles at PC=8 -> two NOP bubbles with if_valid=0, PC stays 8, then the word at 8 enters with pc_plus4=12.
REQ-035: stall high 3 cycles while the word at 8 (0xAB) completes -> IF_ID unchanged, state HELD, imem_req=0, PC=12; stall drop -> IF_ID=0xAB, pc_plus4=12, then fetch resumes at 12.
REQ-036: redirect with redirect_pc=0x103 during HELD with stall=1 -> buffer dropped, IF_ID=NOP, next imem_addr=0x100.
REQ-037: PC=0xFFFF_FFFC with completion -> next imem_addr=0x0000_0000, pc_plus4=0x0000_0000.
REQ-038: rst_n low for one cycle while HELD -> PC=RESET_PC, if_valid=0, imem_req=0 that cycle, and the buffered word never reaches IF_ID.

Source files
------------

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Groups every signal of the instruction-fetch stage except clock and reset.
//
// Signals:
//   stall        hazard hold from the pipeline control
//   redirect     taken branch / jump
//   redirect_pc  branch / jump target
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch address (current PC)
//   imem_ready   memory returns imem_rdata this cycle
//   imem_rdata   fetched instruction word
//   IF_ID        instruction register feeding decode
//   pc_plus4     PC+4 of the instruction held in IF_ID
//   if_valid     IF_ID holds a real instruction (not a bubble)
//
// Modports:
//   slave  - the fetch stage itself
//   master - the surrounding pipeline / memory / testbench
// ---------------------------------------------------------------------------
interface if_stage_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] IF_ID;
   logic [31:0] pc_plus4;
   logic        if_valid;

   modport slave (
      input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
      output imem_req, imem_addr, IF_ID, pc_plus4, if_valid
   );

   modport master (
      output stall, redirect, redirect_pc, imem_ready, imem_rdata,
      input  imem_req, imem_addr, IF_ID, pc_plus4, if_valid
   );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Keeps the PC, issues fetches to instruction memory
// and loads the IF_ID register. A one-entry buffer (state HELD) parks a word
// that completes while decode is stalled so nothing is lost or duplicated.
//
// Parameters:
//   RESET_PC  PC loaded at reset
//   NOP       bubble instruction placed in IF_ID
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    if_stage_if.slave (control, memory bus and IF_ID outputs)
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst_n,
   if_stage_if.slave  bus
);

   typedef enum logic {FETCH, HELD} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ifid;
   logic [31:0] r_pcPlus4;
   logic        r_valid;
   logic [31:0] r_bufInstr;
   logic [31:0] r_bufPcPlus4;

   logic        w_req;
   logic        w_fire;
   logic [31:0] w_pcNext;
   logic [31:0] w_target;

   // A request only goes out while we can accept the word: in FETCH, out of
   // reset, and not in a cycle where a redirect is about to replace the PC.
   assign w_req    = (r_state == FETCH) && rst_n && !bus.redirect;
   assign w_fire   = w_req && bus.imem_ready;
   assign w_pcNext = r_pc + 32'd4;
   // Targets are forced to word alignment by clearing the two low bits.
   assign w_target = bus.redirect_pc & ~32'd3;

   assign bus.imem_req  = w_req;
   assign bus.imem_addr = r_pc;
   assign bus.IF_ID     = r_ifid;
   assign bus.pc_plus4  = r_pcPlus4;
   assign bus.if_valid  = r_valid;

   // Single state machine for the whole stage. Priority is
   // reset > redirect > stall > normal flow. In HELD the buffered word is
   // already accounted for in the PC, so releasing it leaves the PC alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= FETCH;
         r_pc         <= RESET_PC;
         r_ifid       <= NOP;
         r_pcPlus4    <= RESET_PC;
         r_valid      <= 1'b0;
         r_bufInstr   <= 32'h0000_0000;
         r_bufPcPlus4 <= 32'h0000_0000;
      end else if (bus.redirect) begin
         r_state      <= FETCH;
         r_pc         <= w_target;
         r_ifid       <= NOP;
         r_valid      <= 1'b0;
         r_bufInstr   <= 32'h0000_0000;
         r_bufPcPlus4 <= 32'h0000_0000;
      end else if (bus.stall) begin
         // A word landing under stall is parked; IF_ID stays frozen.
         if (w_fire) begin
            r_bufInstr   <= bus.imem_rdata;
            r_bufPcPlus4 <= w_pcNext;
            r_pc         <= w_pcNext;
            r_state      <= HELD;
         end
      end else if (r_state == HELD) begin
         r_ifid    <= r_bufInstr;
         r_pcPlus4 <= r_bufPcPlus4;
         r_valid   <= 1'b1;
         r_state   <= FETCH;
      end else if (w_fire) begin
         r_ifid    <= bus.imem_rdata;
         r_pcPlus4 <= w_pcNext;
         r_valid   <= 1'b1;
         r_pc      <= w_pcNext;
      end else begin
         r_ifid  <= NOP;
         r_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Directed and random checks of the fetch stage. Each directed row drives one
// cycle of inputs, checks the request/address seen before the edge, and
// pushes the expected post-edge IF_ID/pc_plus4/if_valid into a scoreboard
// queue that is popped right after the edge.
// ---------------------------------------------------------------------------
module tb_if_stage;

   localparam logic [31:0] NOPW = 32'h0000_0013;

   typedef struct {
      logic        rstn;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic [31:0] rdata;
      logic        eReq;
      logic [31:0] eAddr;
      logic [31:0] eIfid;
      logic [31:0] ePc4;
      logic        eValid;
   } row_t;

   typedef struct {
      logic [31:0] ifid;
      logic [31:0] pc4;
      logic        valid;
   } exp_t;

   logic clk;
   logic rst_n;
   int   vecCount;
   int   missCount;
   exp_t sbq[$];

   if_stage_if ifc ();

   if_stage #(.RESET_PC(32'h0000_0000), .NOP(NOPW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic row_t mk(logic rstn, logic stall, logic redir,
                               logic [31:0] rpc, logic ready,
                               logic [31:0] rdata, logic eReq,
                               logic [31:0] eAddr, logic [31:0] eIfid,
                               logic [31:0] ePc4, logic eValid);
      row_t r;
      r.rstn = rstn; r.stall = stall; r.redir = redir; r.rpc = rpc;
      r.ready = ready; r.rdata = rdata; r.eReq = eReq; r.eAddr = eAddr;
      r.eIfid = eIfid; r.ePc4 = ePc4; r.eValid = eValid;
      return r;
   endfunction

   // Drives one cycle of inputs on the falling edge and records what the
   // registered outputs must look like after the next rising edge.
   task automatic applyStimulus(input row_t r);
      exp_t e;
      @(negedge clk);
      rst_n           = r.rstn;
      ifc.stall       = r.stall;
      ifc.redirect    = r.redir;
      ifc.redirect_pc = r.rpc;
      ifc.imem_ready  = r.ready;
      ifc.imem_rdata  = r.rdata;
      e.ifid  = r.eIfid;
      e.pc4   = r.ePc4;
      e.valid = r.eValid;
      sbq.push_back(e);
      #1;
   endtask

   // Holds reset low across two rising edges with all inputs quiet.
   task automatic doReset;
      @(negedge clk);
      rst_n           = 1'b0;
      ifc.stall       = 1'b0;
      ifc.redirect    = 1'b0;
      ifc.redirect_pc = 32'h0;
      ifc.imem_ready  = 1'b0;
      ifc.imem_rdata  = 32'h0;
      @(posedge clk);
      @(posedge clk);
      sbq.delete();
   endtask

   task automatic test_reset;
      row_t rows[$];
      exp_t e;
      doReset();
      rows.push_back(mk(0,0,0,0, 1,32'hDEAD, 0,32'h0, NOPW,32'h0,0));
      rows.push_back(mk(1,0,0,0, 0,32'h0,    1,32'h0, NOPW,32'h0,0));
      rows.push_back(mk(1,0,0,0, 1,32'h11,   1,32'h0, 32'h11,32'h4,1));
      rows.push_back(mk(0,0,0,0, 1,32'h22,   0,32'h4, NOPW,32'h0,0));
      rows.push_back(mk(1,0,0,0, 0,32'h0,    1,32'h0, NOPW,32'h0,0));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         vecCount++;
         if (ifc.imem_req !== rows[i].eReq || ifc.imem_addr !== rows[i].eAddr) begin
            missCount++;
            $display("[TB] FAIL reset.req[%0d] got req=%b addr=%h want req=%b addr=%h",
                     i, ifc.imem_req, ifc.imem_addr, rows[i].eReq, rows[i].eAddr);
         end
         @(posedge clk); #1;
         e = sbq.pop_front();
         vecCount++;
         if (ifc.IF_ID !== e.ifid || ifc.pc_plus4 !== e.pc4 || ifc.if_valid !== e.valid) begin
            missCount++;
            $display("[TB] FAIL reset.out[%0d] got %h/%h/%b want %h/%h/%b",
                     i, ifc.IF_ID, ifc.pc_plus4, ifc.if_valid, e.ifid, e.pc4, e.valid);
         end
      end
   endtask

   task automatic test_stream;
      row_t rows[$];
      exp_t e;
      doReset();
      rows.push_back(mk(1,0,0,0, 1,32'h11, 1,32'h0,  32'h11,32'h4, 1));
      rows.push_back(mk(1,0,0,0, 1,32'h22, 1,32'h4,  32'h22,32'h8, 1));
      rows.push_back(mk(1,0,0,0, 0,32'h0,  1,32'h8,  NOPW,  32'h8, 0));
      rows.push_back(mk(1,0,0,0, 0,32'h0,  1,32'h8,  NOPW,  32'h8, 0));
      rows.push_back(mk(1,0,0,0, 1,32'h33, 1,32'h8,  32'h33,32'hC, 1));
      rows.push_back(mk(1,0,0,0, 1,32'h44, 1,32'hC,  32'h44,32'h10,1));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         vecCount++;
         if (ifc.imem_req !== rows[i].eReq || ifc.imem_addr !== rows[i].eAddr) begin
            missCount++;
            $display("[TB] FAIL stream.req[%0d] got req=%b addr=%h want req=%b addr=%h",
                     i, ifc.imem_req, ifc.imem_addr, rows[i].eReq, rows[i].eAddr);
         end
         @(posedge clk); #1;
         e = sbq.pop_front();
         vecCount++;
         if (ifc.IF_ID !== e.ifid || ifc.pc_plus4 !== e.pc4 || ifc.if_valid !== e.valid) begin
            missCount++;
            $display("[TB] FAIL stream.out[%0d] got %h/%h/%b want %h/%h/%b",
                     i, ifc.IF_ID, ifc.pc_plus4, ifc.if_valid, e.ifid, e.pc4, e.valid);
         end
      end
   endtask

   task automatic test_stall;
      row_t rows[$];
      exp_t e;
      doReset();
      rows.push_back(mk(1,0,0,0, 1,32'h11, 1,32'h0, 32'h11,32'h4, 1));
      rows.push_back(mk(1,0,0,0, 1,32'h22, 1,32'h4, 32'h22,32'h8, 1));
      rows.push_back(mk(1,1,0,0, 0,32'h0,  1,32'h8, 32'h22,32'h8, 1));
      rows.push_back(mk(1,1,0,0, 1,32'hAB, 1,32'h8, 32'h22,32'h8, 1));
      rows.push_back(mk(1,1,0,0, 1,32'hEE, 0,32'hC, 32'h22,32'h8, 1));
      rows.push_back(mk(1,1,0,0, 1,32'hEE, 0,32'hC, 32'h22,32'h8, 1));
      rows.push_back(mk(1,0,0,0, 1,32'hEE, 0,32'hC, 32'hAB,32'hC, 1));
      rows.push_back(mk(1,0,0,0, 1,32'hCC, 1,32'hC, 32'hCC,32'h10,1));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         vecCount++;
         if (ifc.imem_req !== rows[i].eReq || ifc.imem_addr !== rows[i].eAddr) begin
            missCount++;
            $display("[TB] FAIL stall.req[%0d] got req=%b addr=%h want req=%b addr=%h",
                     i, ifc.imem_req, ifc.imem_addr, rows[i].eReq, rows[i].eAddr);
         end
         @(posedge clk); #1;
         e = sbq.pop_front();
         vecCount++;
         if (ifc.IF_ID !== e.ifid || ifc.pc_plus4 !== e.pc4 || ifc.if_valid !== e.valid) begin
            missCount++;
            $display("[TB] FAIL stall.out[%0d] got %h/%h/%b want %h/%h/%b",
                     i, ifc.IF_ID, ifc.pc_plus4, ifc.if_valid, e.ifid, e.pc4, e.valid);
         end
      end
   endtask

   task automatic test_redirect;
      row_t rows[$];
      exp_t e;
      doReset();
      rows.push_back(mk(1,0,0,32'h0,   1,32'h11, 1,32'h0,   32'h11,32'h4,  1));
      rows.push_back(mk(1,1,0,32'h0,   1,32'h22, 1,32'h4,   32'h11,32'h4,  1));
      rows.push_back(mk(1,1,1,32'h103, 1,32'h33, 0,32'h8,   NOPW,  32'h4,  0));
      rows.push_back(mk(1,0,0,32'h0,   0,32'h0,  1,32'h100, NOPW,  32'h4,  0));
      rows.push_back(mk(1,0,0,32'h0,   1,32'h55, 1,32'h100, 32'h55,32'h104,1));
      rows.push_back(mk(1,0,1,32'h200, 1,32'h66, 0,32'h104, NOPW,  32'h104,0));
      rows.push_back(mk(1,0,0,32'h0,   1,32'h77, 1,32'h200, 32'h77,32'h204,1));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         vecCount++;
         if (ifc.imem_req !== rows[i].eReq || ifc.imem_addr !== rows[i].eAddr) begin
            missCount++;
            $display("[TB] FAIL redirect.req[%0d] got req=%b addr=%h want req=%b addr=%h",
                     i, ifc.imem_req, ifc.imem_addr, rows[i].eReq, rows[i].eAddr);
         end
         @(posedge clk); #1;
         e = sbq.pop_front();
         vecCount++;
         if (ifc.IF_ID !== e.ifid || ifc.pc_plus4 !== e.pc4 || ifc.if_valid !== e.valid) begin
            missCount++;
            $display("[TB] FAIL redirect.out[%0d] got %h/%h/%b want %h/%h/%b",
                     i, ifc.IF_ID, ifc.pc_plus4, ifc.if_valid, e.ifid, e.pc4, e.valid);
         end
      end
   endtask

   task automatic test_wrap;
      row_t rows[$];
      exp_t e;
      doReset();
      rows.push_back(mk(1,0,1,32'hFFFF_FFFF, 0,32'h0,  0,32'h0,         NOPW,  32'h0,1'b0));
      rows.push_back(mk(1,0,0,32'h0,         1,32'h99, 1,32'hFFFF_FFFC, 32'h99,32'h0,1'b1));
      rows.push_back(mk(1,0,0,32'h0,         1,32'h9A, 1,32'h0,         32'h9A,32'h4,1'b1));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         vecCount++;
         if (ifc.imem_req !== rows[i].eReq || ifc.imem_addr !== rows[i].eAddr) begin
            missCount++;
            $display("[TB] FAIL wrap.req[%0d] got req=%b addr=%h want req=%b addr=%h",
                     i, ifc.imem_req, ifc.imem_addr, rows[i].eReq, rows[i].eAddr);
         end
         @(posedge clk); #1;
         e = sbq.pop_front();
         vecCount++;
         if (ifc.IF_ID !== e.ifid || ifc.pc_plus4 !== e.pc4 || ifc.if_valid !== e.valid) begin
            missCount++;
            $display("[TB] FAIL wrap.out[%0d] got %h/%h/%b want %h/%h/%b",
                     i, ifc.IF_ID, ifc.pc_plus4, ifc.if_valid, e.ifid, e.pc4, e.valid);
         end
      end
   endtask

   task automatic test_reset_held;
      row_t rows[$];
      exp_t e;
      doReset();
      rows.push_back(mk(1,0,0,0, 1,32'h11, 1,32'h0, 32'h11,32'h4,1));
      rows.push_back(mk(1,1,0,0, 1,32'h22, 1,32'h4, 32'h11,32'h4,1));
      rows.push_back(mk(0,0,0,0, 1,32'h33, 0,32'h8, NOPW,  32'h0,0));
      rows.push_back(mk(1,0,0,0, 0,32'h0,  1,32'h0, NOPW,  32'h0,0));
      rows.push_back(mk(1,0,0,0, 1,32'h11, 1,32'h0, 32'h11,32'h4,1));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         vecCount++;
         if (ifc.imem_req !== rows[i].eReq || ifc.imem_addr !== rows[i].eAddr) begin
            missCount++;
            $display("[TB] FAIL rstheld.req[%0d] got req=%b addr=%h want req=%b addr=%h",
                     i, ifc.imem_req, ifc.imem_addr, rows[i].eReq, rows[i].eAddr);
         end
         @(posedge clk); #1;
         e = sbq.pop_front();
         vecCount++;
         if (ifc.IF_ID !== e.ifid || ifc.pc_plus4 !== e.pc4 || ifc.if_valid !== e.valid) begin
            missCount++;
            $display("[TB] FAIL rstheld.out[%0d] got %h/%h/%b want %h/%h/%b",
                     i, ifc.IF_ID, ifc.pc_plus4, ifc.if_valid, e.ifid, e.pc4, e.valid);
         end
      end
   endtask

   // Random stall/ready interleaving. Memory answers with a word derived from
   // the address; the expected stream is the linear program order, so any lost
   // or duplicated instruction shows up as a miscompare.
   task automatic test_back_to_back;
      exp_t        e;
      logic [31:0] lastIfid;
      logic [31:0] lastPc4;
      logic        lastValid;
      logic        wasStall;
      int          delivered;
      doReset();
      for (int k = 0; k < 300; k++) begin
         e.ifid  = (32'(k) * 32'd4) ^ 32'h5A5A_0000;
         e.pc4   = 32'(k) * 32'd4 + 32'd4;
         e.valid = 1'b1;
         sbq.push_back(e);
      end
      lastIfid  = NOPW;
      lastPc4   = 32'h0;
      lastValid = 1'b0;
      delivered = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         rst_n          = 1'b1;
         ifc.redirect   = 1'b0;
         ifc.stall      = ($urandom_range(0, 2) == 0);
         ifc.imem_ready = 1'($urandom_range(0, 1));
         ifc.imem_rdata = ifc.imem_addr ^ 32'h5A5A_0000;
         wasStall       = ifc.stall;
         @(posedge clk); #1;
         vecCount++;
         if (wasStall) begin
            if (ifc.IF_ID !== lastIfid || ifc.pc_plus4 !== lastPc4 || ifc.if_valid !== lastValid) begin
               missCount++;
               $display("[TB] FAIL b2b.hold[%0d] got %h/%h/%b want %h/%h/%b",
                        c, ifc.IF_ID, ifc.pc_plus4, ifc.if_valid, lastIfid, lastPc4, lastValid);
            end
         end else if (ifc.if_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               missCount++;
               $display("[TB] FAIL b2b.extra[%0d] got %h want none", c, ifc.IF_ID);
            end else begin
               e = sbq.pop_front();
               delivered++;
               if (ifc.IF_ID !== e.ifid || ifc.pc_plus4 !== e.pc4) begin
                  missCount++;
                  $display("[TB] FAIL b2b.word[%0d] got %h/%h want %h/%h",
                           c, ifc.IF_ID, ifc.pc_plus4, e.ifid, e.pc4);
               end
               lastIfid  = e.ifid;
               lastPc4   = e.pc4;
               lastValid = 1'b1;
            end
         end else begin
            if (ifc.IF_ID !== NOPW || ifc.pc_plus4 !== lastPc4) begin
               missCount++;
               $display("[TB] FAIL b2b.bubble[%0d] got %h/%h want %h/%h",
                        c, ifc.IF_ID, ifc.pc_plus4, NOPW, lastPc4);
            end
            lastIfid  = NOPW;
            lastValid = 1'b0;
         end
      end
      vecCount++;
      if (delivered < 20) begin
         missCount++;
         $display("[TB] FAIL b2b.count got %0d want >= 20", delivered);
      end
      sbq.delete();
   endtask

   // Runs every scenario in order, then prints the single summary line.
   initial begin
      vecCount  = 0;
      missCount = 0;
      rst_n     = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_reset_held();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
